// File: rtl/mem_arbiter_if.sv
// Bus bundle between the three memory requesters, the arbiter and the shared memory.
// The slave modport is the arbiter's view; master is the requester/memory side.
interface mem_arbiter_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              ld_req;
    logic              ld_we;
    logic [ADDR_W-1:0] ld_addr;
    logic [DATA_W-1:0] ld_wdata;
    logic [2:0]        ack;
    logic [2:0]        err;
    logic [DATA_W-1:0] rdata;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_we;
    logic [DATA_W-1:0] mem_rdata;
    logic [1:0]        grant;

    modport slave (
        input  if_req, if_addr,
        input  d_req, d_we, d_addr, d_wdata,
        input  ld_req, ld_we, ld_addr, ld_wdata,
        input  mem_rdata,
        output ack, err, rdata, grant,
        output mem_addr, mem_wdata, mem_we
    );

    modport master (
        output if_req, if_addr,
        output d_req, d_we, d_addr, d_wdata,
        output ld_req, ld_we, ld_addr, ld_wdata,
        output mem_rdata,
        input  ack, err, rdata, grant,
        input  mem_addr, mem_wdata, mem_we
    );
endinterface

// File: rtl/mem_arbiter.sv
// Three-port arbiter onto one synchronous single-port memory: fetch (read-only), data, loader.
// Loader has absolute priority; fetch and data alternate round-robin. Each access takes 2 cycles.
module mem_arbiter #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input logic          clk,
    input logic          resetn,
    mem_arbiter_if.slave bus
);

    typedef enum logic [1:0] {StIdle, StIssue, StDone} state_e;

    state_e            state_q, state_d;
    logic [1:0]        grant_q, grant_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              mem_we_q, mem_we_d;
    logic              is_read_q, is_read_d;
    logic              misal_q, misal_d;
    logic [2:0]        ack_q, ack_d;
    logic [2:0]        err_q, err_d;
    // 1 = port 1 served last among ports 0/1, so port 0 wins the next tie
    logic              rr_last_q, rr_last_d;

    logic [2:0]        pend;
    logic [1:0]        win;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic              sel_we;
    logic              sel_misal;

    always_comb begin
        pend = {bus.ld_req, bus.d_req, bus.if_req};
        // The port acked this cycle may still hold req; it must not be re-served immediately
        if (state_q == StDone) begin
            case (grant_q)
                2'd0:    pend[0] = 1'b0;
                2'd1:    pend[1] = 1'b0;
                2'd2:    pend[2] = 1'b0;
                default: ;
            endcase
        end
    end

    always_comb begin
        if (pend[2]) begin
            win = 2'd2;
        end else if (pend[0] && pend[1]) begin
            win = rr_last_q ? 2'd0 : 2'd1;
        end else if (pend[0]) begin
            win = 2'd0;
        end else if (pend[1]) begin
            win = 2'd1;
        end else begin
            win = 2'd3;
        end
    end

    always_comb begin
        case (win)
            2'd1: begin
                sel_addr  = bus.d_addr;
                sel_wdata = bus.d_wdata;
                sel_we    = bus.d_we;
            end
            2'd2: begin
                sel_addr  = bus.ld_addr;
                sel_wdata = bus.ld_wdata;
                sel_we    = bus.ld_we;
            end
            default: begin
                sel_addr  = bus.if_addr;
                sel_wdata = '0;
                sel_we    = 1'b0;
            end
        endcase
        sel_misal = |sel_addr[1:0];
    end

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_we_d    = 1'b0;
        is_read_d   = is_read_q;
        misal_d     = misal_q;
        ack_d       = 3'b000;
        err_d       = 3'b000;
        rr_last_d   = rr_last_q;

        case (state_q)
            StIdle, StDone: begin
                if (|pend) begin
                    state_d     = StIssue;
                    grant_d     = win;
                    mem_addr_d  = sel_addr;
                    mem_wdata_d = sel_wdata;
                    mem_we_d    = sel_we && !sel_misal;
                    is_read_d   = !sel_we;
                    misal_d     = sel_misal;
                end else begin
                    state_d = StIdle;
                    grant_d = 2'd3;
                end
            end
            StIssue: begin
                state_d = StDone;
                case (grant_q)
                    2'd0: begin
                        ack_d     = 3'b001;
                        rr_last_d = 1'b0;
                    end
                    2'd1: begin
                        ack_d     = 3'b010;
                        rr_last_d = 1'b1;
                    end
                    2'd2:    ack_d = 3'b100;
                    default: ack_d = 3'b000;
                endcase
                err_d = misal_q ? ack_d : 3'b000;
            end
            default: begin
                state_d = StIdle;
                grant_d = 2'd3;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= StIdle;
            grant_q     <= 2'd3;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_we_q    <= 1'b0;
            is_read_q   <= 1'b0;
            misal_q     <= 1'b0;
            ack_q       <= 3'b000;
            err_q       <= 3'b000;
            rr_last_q   <= 1'b1;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_we_q    <= mem_we_d;
            is_read_q   <= is_read_d;
            misal_q     <= misal_d;
            ack_q       <= ack_d;
            err_q       <= err_d;
            rr_last_q   <= rr_last_d;
        end
    end

    assign bus.ack       = ack_q;
    assign bus.err       = err_q;
    assign bus.grant     = grant_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.mem_we    = mem_we_q;
    // Memory read data arrives in DONE; misaligned reads and writes return zero
    assign bus.rdata     = (state_q == StDone && is_read_q && !misal_q) ? bus.mem_rdata : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: vector table, directed multi-cycle sequences and randomized
// requesters checked against a transaction-level memory/arbitration model.
module tb_mem_arbiter;

    logic clk = 1'b0;
    logic resetn = 1'b1;
    always #5 clk = ~clk;

    mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus.slave)
    );

    int total = 0;
    int bad = 0;

    // Synchronous memory, with a back-door write port for preloading while the arbiter is idle
    logic [31:0] mem [0:255];
    logic        pre_we = 1'b0;
    logic [7:0]  pre_idx = '0;
    logic [31:0] pre_data = '0;

    always @(posedge clk) begin
        if (pre_we) mem[pre_idx] <= pre_data;
        else if (bus.mem_we) mem[bus.mem_addr[9:2]] <= bus.mem_wdata;
        bus.mem_rdata <= mem[bus.mem_addr[9:2]];
    end

    typedef struct {
        int          port;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [2:0]  ack;
        logic [2:0]  err;
        logic        mem_we;
        logic        chk_rd;
        logic [31:0] rdata;
    } vec_t;

    vec_t tbl [12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_port(input int p, input logic on, input logic we,
                            input logic [31:0] a, input logic [31:0] wd);
        case (p)
            0: begin bus.if_req = on; bus.if_addr = a; end
            1: begin bus.d_req = on; bus.d_we = we; bus.d_addr = a; bus.d_wdata = wd; end
            default: begin bus.ld_req = on; bus.ld_we = we; bus.ld_addr = a; bus.ld_wdata = wd; end
        endcase
    endtask

    task automatic clear_inputs();
        for (int k = 0; k < 3; k++) set_port(k, 1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        clear_inputs();
        repeat (2) @(posedge clk);
        @(negedge clk);
        resetn = 1'b1;
    endtask

    task automatic preload(input logic [7:0] idx, input logic [31:0] d);
        @(posedge clk); #1;
        pre_we = 1'b1; pre_idx = idx; pre_data = d;
        @(posedge clk); #1;
        pre_we = 1'b0;
    endtask

    task automatic do_access(input vec_t v);
        @(posedge clk); #1;
        set_port(v.port, 1'b1, v.we, v.addr, v.wdata);
        @(posedge clk); #1;
        check("issue_grant", 32'(bus.grant), v.port);
        check("issue_mem_we", 32'(bus.mem_we), 32'(v.mem_we));
        if (v.mem_we) begin
            check("issue_mem_addr", bus.mem_addr, v.addr);
            check("issue_mem_wdata", bus.mem_wdata, v.wdata);
        end
        @(posedge clk); #1;
        check("done_ack", 32'(bus.ack), 32'(v.ack));
        check("done_err", 32'(bus.err), 32'(v.err));
        check("done_mem_we", 32'(bus.mem_we), 32'd0);
        if (v.chk_rd) check("done_rdata", bus.rdata, v.rdata);
        set_port(v.port, 1'b0, 1'b0, 32'h0, 32'h0);
        @(posedge clk); #1;
        check("idle_ack", 32'(bus.ack), 32'd0);
        check("idle_grant", 32'(bus.grant), 32'd3);
    endtask

    // Randomized-phase requester state
    logic        outst [3];
    int          st [3];
    logic        wr [3];
    logic [31:0] ad [3];
    logic [31:0] wd [3];
    logic        just [3];
    int          wins [2];
    logic [31:0] ref_mem [16];

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got running expected done");
        $fatal(1);
    end

    initial begin
        logic [2:0] exp_seq [9];
        int         order [3];
        int         cnt;

        tbl[0]  = '{0, 1'b0, 32'h10,  32'h0,        3'b001, 3'b000, 1'b0, 1'b1, 32'h00500093};
        tbl[1]  = '{1, 1'b1, 32'h100, 32'hDEADBEEF, 3'b010, 3'b000, 1'b1, 1'b0, 32'h0};
        tbl[2]  = '{0, 1'b0, 32'h100, 32'h0,        3'b001, 3'b000, 1'b0, 1'b1, 32'hDEADBEEF};
        tbl[3]  = '{1, 1'b1, 32'h102, 32'h55555555, 3'b010, 3'b010, 1'b0, 1'b0, 32'h0};
        tbl[4]  = '{0, 1'b0, 32'h100, 32'h0,        3'b001, 3'b000, 1'b0, 1'b1, 32'hDEADBEEF};
        tbl[5]  = '{2, 1'b1, 32'h20,  32'h12345678, 3'b100, 3'b000, 1'b1, 1'b0, 32'h0};
        tbl[6]  = '{1, 1'b0, 32'h20,  32'h0,        3'b010, 3'b000, 1'b0, 1'b1, 32'h12345678};
        tbl[7]  = '{0, 1'b0, 32'h11,  32'h0,        3'b001, 3'b001, 1'b0, 1'b1, 32'h0};
        tbl[8]  = '{2, 1'b0, 32'h20,  32'h0,        3'b100, 3'b000, 1'b0, 1'b1, 32'h12345678};
        tbl[9]  = '{1, 1'b0, 32'h23,  32'h0,        3'b010, 3'b010, 1'b0, 1'b1, 32'h0};
        tbl[10] = '{2, 1'b1, 32'h21,  32'hAAAA0000, 3'b100, 3'b100, 1'b0, 1'b0, 32'h0};
        tbl[11] = '{2, 1'b0, 32'h20,  32'h0,        3'b100, 3'b000, 1'b0, 1'b1, 32'h12345678};

        clear_inputs();
        #2 resetn = 1'b0;
        #1;
        check("rst_ack", 32'(bus.ack), 32'd0);
        check("rst_err", 32'(bus.err), 32'd0);
        check("rst_mem_we", 32'(bus.mem_we), 32'd0);
        check("rst_grant", 32'(bus.grant), 32'd3);
        check("rst_mem_addr", bus.mem_addr, 32'd0);
        check("rst_mem_wdata", bus.mem_wdata, 32'd0);
        check("rst_rdata", bus.rdata, 32'd0);
        do_reset();

        preload(8'h04, 32'h00500093);
        foreach (tbl[i]) do_access(tbl[i]);

        // Fetch and data held from reset: strict alternation, first ack two edges in
        exp_seq = '{3'b000, 3'b001, 3'b000, 3'b010, 3'b000, 3'b001, 3'b000, 3'b010, 3'b000};
        resetn = 1'b0;
        clear_inputs();
        set_port(0, 1'b1, 1'b0, 32'h10, 32'h0);
        set_port(1, 1'b1, 1'b0, 32'h14, 32'h0);
        @(posedge clk);
        @(negedge clk);
        resetn = 1'b1;
        for (int e = 0; e < 9; e++) begin
            @(posedge clk); #1;
            check("alt_ack", 32'(bus.ack), 32'(exp_seq[e]));
            check("alt_no_we", 32'(bus.mem_we), 32'd0);
            if (e == 0) check("alt_first_grant", 32'(bus.grant), 32'd0);
        end
        clear_inputs();
        repeat (4) @(posedge clk);

        // All three requesting: loader first, then fetch, then data
        do_reset();
        @(posedge clk); #1;
        set_port(2, 1'b1, 1'b0, 32'h20, 32'h0);
        set_port(0, 1'b1, 1'b0, 32'h10, 32'h0);
        set_port(1, 1'b1, 1'b0, 32'h14, 32'h0);
        order = '{7, 7, 7};
        cnt = 0;
        for (int n = 0; n < 20 && cnt < 3; n++) begin
            @(posedge clk); #1;
            if (bus.ack != 3'b000) begin
                int p;
                p = bus.ack[2] ? 2 : (bus.ack[1] ? 1 : 0);
                order[cnt] = p;
                cnt++;
                set_port(p, 1'b0, 1'b0, 32'h0, 32'h0);
            end
        end
        check("prio_first", order[0], 32'd2);
        check("prio_second", order[1], 32'd0);
        check("prio_third", order[2], 32'd1);
        repeat (3) @(posedge clk);

        // Reset while a store is in ISSUE: write aborted, no ack, then normal service
        @(posedge clk); #1;
        set_port(1, 1'b1, 1'b1, 32'h100, 32'hCAFEF00D);
        @(posedge clk); #1;
        check("abort_issue_we", 32'(bus.mem_we), 32'd1);
        #2 resetn = 1'b0;
        #1;
        check("abort_we_drop", 32'(bus.mem_we), 32'd0);
        check("abort_grant", 32'(bus.grant), 32'd3);
        check("abort_ack", 32'(bus.ack), 32'd0);
        set_port(1, 1'b0, 1'b0, 32'h0, 32'h0);
        @(posedge clk);
        @(negedge clk);
        resetn = 1'b1;
        for (int n = 0; n < 3; n++) begin
            @(posedge clk); #1;
            check("abort_no_ack", 32'(bus.ack), 32'd0);
        end
        do_access(tbl[2]);

        // Randomized traffic against a transaction-level model
        do_reset();
        for (int i = 0; i < 16; i++) begin
            ref_mem[i] = $urandom;
            preload(8'(i), ref_mem[i]);
        end
        for (int k = 0; k < 3; k++) begin
            outst[k] = 1'b0; st[k] = 0; wr[k] = 1'b0; ad[k] = '0; wd[k] = '0;
        end
        wins[0] = 0;
        wins[1] = 0;
        for (int c = 0; c < 3100; c++) begin
            @(posedge clk); #1;
            for (int k = 0; k < 3; k++) just[k] = 1'b0;
            if (bus.mem_we) begin
                int g;
                g = int'(bus.grant);
                check("rnd_we_grant", 32'(g == 1 || g == 2), 32'd1);
                if (g == 1 || g == 2) begin
                    check("rnd_we_legal", 32'(outst[g] && wr[g] && ad[g][1:0] == 2'b00), 32'd1);
                    check("rnd_we_addr", bus.mem_addr, ad[g]);
                    check("rnd_we_wdata", bus.mem_wdata, wd[g]);
                end
            end
            if (bus.ack != 3'b000) begin
                int   p;
                logic mis;
                p = bus.ack[2] ? 2 : (bus.ack[1] ? 1 : 0);
                check("rnd_ack_onehot", $countones(bus.ack), 32'd1);
                check("rnd_ack_pending", 32'(outst[p]), 32'd1);
                mis = ad[p][1:0] != 2'b00;
                check("rnd_err", 32'(bus.err), mis ? 32'(bus.ack) : 32'd0);
                if (!wr[p]) check("rnd_rdata", bus.rdata, mis ? 32'd0 : ref_mem[ad[p][5:2]]);
                else if (!mis) ref_mem[ad[p][5:2]] = wd[p];
                if (p != 2 && outst[2] && st[2] <= c - 2) check("rnd_ld_priority", p, 32'd2);
                if (p < 2) begin
                    int q;
                    q = 1 - p;
                    if (outst[q] && st[q] <= c - 2) begin
                        check("rnd_rr_fair", wins[q], 32'd0);
                        wins[q]++;
                    end
                end
                outst[p] = 1'b0;
                just[p] = 1'b1;
                set_port(p, 1'b0, 1'b0, 32'h0, 32'h0);
            end else begin
                check("rnd_err_quiet", 32'(bus.err), 32'd0);
            end
            for (int k = 0; k < 3; k++) begin
                if (outst[k] && c - st[k] > 60) begin
                    check("rnd_latency", c - st[k], 32'd60);
                    outst[k] = 1'b0;
                    set_port(k, 1'b0, 1'b0, 32'h0, 32'h0);
                end
            end
            if (c < 3000) begin
                for (int k = 0; k < 3; k++) begin
                    if (!outst[k] && !just[k] && $urandom_range(0, (k == 2) ? 5 : 1) == 0) begin
                        int r;
                        r = $urandom_range(0, 15);
                        ad[k] = {26'd0, 4'(r), 2'b00};
                        if ($urandom_range(0, 7) == 0) ad[k][1:0] = 2'($urandom_range(1, 3));
                        wr[k] = (k == 0) ? 1'b0 : 1'($urandom_range(0, 1));
                        wd[k] = $urandom;
                        outst[k] = 1'b1;
                        st[k] = c;
                        if (k < 2) wins[k] = 0;
                        set_port(k, 1'b1, wr[k], ad[k], wd[k]);
                    end
                end
            end
        end
        for (int k = 0; k < 3; k++) check("rnd_drained", 32'(outst[k]), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
